// File: rtl/series_pkg.sv
// Shared constants and types for the e^-x style series datapath (Q2.14).
package series_pkg;
  localparam int DW     = 16;
  localparam int DFRAC  = DW - 2;
  localparam int CW     = 3;
  localparam logic [DW-1:0] ONE     = 16'h4000;
  localparam logic [DW-1:0] EPS_DEF = 16'h0004;

  typedef logic [DW-1:0] coef_t;

  // round(ONE/(k+1)) for k = 0..7
  localparam coef_t COEF [0:7] = '{
    16'h4000, 16'h2000, 16'h1555, 16'h1000,
    16'h0CCD, 16'h0AAB, 16'h0925, 16'h0800
  };
endpackage

// File: rtl/series_datapath_coef_rom.sv
// Reciprocal coefficient table indexed by the term counter.
module coef_rom
  import series_pkg::*;
(
  input  logic [CW-1:0] i_addr,
  output coef_t         o_coef
);
  always_comb begin
    case (i_addr)
      3'd0:    o_coef = COEF[0];
      3'd1:    o_coef = COEF[1];
      3'd2:    o_coef = COEF[2];
      3'd3:    o_coef = COEF[3];
      3'd4:    o_coef = COEF[4];
      3'd5:    o_coef = COEF[5];
      3'd6:    o_coef = COEF[6];
      default: o_coef = COEF[7];
    endcase
  end
endmodule

// File: rtl/series_datapath.sv
// Series datapath: term register t, accumulator r, operand x and term counter,
// driven by controller strobes; reports co (last term) and gt (converged).
module series_datapath
  import series_pkg::*;
#(
  parameter int              W     = DW,
  parameter int              CNT_W = CW,
  parameter logic [W-1:0]    EPS   = EPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     x_in,
  input  logic             initr,
  input  logic             initt,
  input  logic             zc,
  input  logic             ldx,
  input  logic             s,
  input  logic             ldt,
  input  logic             enc,
  input  logic             ldr,
  input  logic             is_neg,
  output logic             co,
  output logic             gt,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] cnt_out
);
  localparam int           FRAC  = W - 2;
  localparam logic [W-1:0] L_ONE = W'(1) << FRAC;

  logic [W-1:0]     r_x, r_t, r_r;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]   w_coef, w_op, w_tmul, w_sum;
  logic [2*W-1:0] w_prod;

  coef_rom u_rom (
    .i_addr (r_cnt),
    .o_coef (w_coef)
  );

  assign w_op   = s ? w_coef : r_x;
  assign w_prod = r_t * w_op;
  // Anything above the Q2.14 integer range saturates rather than wrapping.
  assign w_tmul = (|w_prod[2*W-1:FRAC+W]) ? '1 : w_prod[FRAC+W-1:FRAC];
  assign w_sum  = is_neg ? (r_r - r_t) : (r_r + r_t);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_t   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else begin
      if (ldx)        r_x   <= x_in;
      if (initt)      r_t   <= L_ONE;
      else if (ldt)   r_t   <= w_tmul;
      if (initr)      r_r   <= L_ONE;
      else if (ldr)   r_r   <= w_sum;
      if (zc)         r_cnt <= '0;
      else if (enc)   r_cnt <= r_cnt + 1'b1;
    end
  end

  assign co      = (r_cnt == '1);
  assign gt      = (r_t < EPS);
  assign result  = r_r;
  assign cnt_out = r_cnt;
endmodule

// File: tb/tb_series_datapath.sv
// Directed bench for series_datapath with hand-computed expectations.
module tb_series_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x_in = '0;
  logic        initr = 0, initt = 0, zc = 0, ldx = 0, s = 0, ldt = 0,
               enc = 0, ldr = 0, is_neg = 0;
  logic        co, gt;
  logic [15:0] result;
  logic [2:0]  cnt_out;

  int npass = 0;
  int ntot  = 0;

  series_datapath dut (
    .clk(clk), .rst(rst), .x_in(x_in),
    .initr(initr), .initt(initt), .zc(zc), .ldx(ldx), .s(s), .ldt(ldt),
    .enc(enc), .ldr(ldr), .is_neg(is_neg),
    .co(co), .gt(gt), .result(result), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic clr();
    initr = 0; initt = 0; zc = 0; ldx = 0; s = 0; ldt = 0;
    enc = 0; ldr = 0; is_neg = 0;
  endtask

  // Apply the currently driven strobes for one edge, then release them.
  task automatic tick();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic mult1(); s = 0; ldt = 1; tick(); endtask
  task automatic mult2(); s = 1; ldt = 1; tick(); endtask

  task automatic term(input logic neg, input logic exp_co, input string tag);
    mult1();
    mult2();
    enc = 1; ldr = 1; is_neg = neg;
    chk({tag, "_co"}, 32'(co), 32'(exp_co));
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cnt", 32'(cnt_out), 32'h0);
    chk("rst_gt", 32'(gt), 32'h1);
    chk("rst_co", 32'(co), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero input converges after one multiply
    x_in = 16'h0000; initr = 1; initt = 1; zc = 1; ldx = 1; tick();
    chk("zero_gt_pre", 32'(gt), 32'h0);
    mult1();
    chk("zero_gt", 32'(gt), 32'h1);
    chk("zero_result", 32'(result), 32'h4000);

    // ldx with MULT1 in the same cycle multiplies by the old x (0)
    initt = 1; tick();
    x_in = 16'h4000; ldx = 1; s = 0; ldt = 1; tick();
    chk("ldx_old_x_gt", 32'(gt), 32'h1);

    // Full series for x = 1.0
    initr = 1; initt = 1; zc = 1; ldx = 1; tick();
    term(1'b1, 1'b0, "t1");
    chk("t1_result", 32'(result), 32'h0000);
    term(1'b0, 1'b0, "t2");
    chk("t2_result", 32'(result), 32'h2000);
    mult1(); mult2();
    chk("t3_term", 32'(gt), 32'h0);
    enc = 1; ldr = 1; is_neg = 1; tick();
    chk("t3_result", 32'(result), 32'h1556);
    term(1'b0, 1'b0, "t4");
    chk("t4_result", 32'(result), 32'h1800);
    term(1'b1, 1'b0, "t5");
    term(1'b0, 1'b0, "t6");
    term(1'b1, 1'b0, "t7");
    chk("t7_cnt", 32'(cnt_out), 32'h7);
    term(1'b0, 1'b1, "t8");
    chk("final_gt", 32'(gt), 32'h1);
    chk("final_range", 32'(result >= 16'h1787 && result <= 16'h178F), 32'h1);
    chk("final_cnt_wrap", 32'(cnt_out), 32'h0);

    // Counter wrap and zc priority
    for (int i = 0; i < 8; i++) begin enc = 1; tick(); end
    chk("wrap8_cnt", 32'(cnt_out), 32'h0);
    enc = 1; tick(); enc = 1; tick(); enc = 1; tick();
    chk("cnt3", 32'(cnt_out), 32'h3);
    zc = 1; enc = 1; tick();
    chk("zc_beats_enc", 32'(cnt_out), 32'h0);

    // Saturation: 1.0 * ~4.0 truncates to FFFF, then overflows
    initt = 1; ldx = 1; x_in = 16'hFFFF; tick();
    mult1();
    chk("sat_first", 32'(dut.r_t), 32'hFFFF);
    mult1();
    chk("sat_second", 32'(dut.r_t), 32'hFFFF);
    chk("sat_gt", 32'(gt), 32'h0);

    // Accumulator wrap: 0x4000 + 0xC000 = 0 mod 2^16
    initt = 1; initr = 1; ldx = 1; x_in = 16'hC000; tick();
    mult1();
    chk("acc_t", 32'(dut.r_t), 32'hC000);
    ldr = 1; is_neg = 0; tick();
    chk("acc_wrap", 32'(result), 32'h0000);
    initr = 1; ldr = 1; tick();
    chk("initr_beats_ldr", 32'(result), 32'h4000);
    initt = 1; ldt = 1; s = 0; tick();
    chk("initt_beats_ldt", 32'(dut.r_t), 32'h4000);

    // Hold with no strobes
    repeat (3) tick();
    chk("hold_result", 32'(result), 32'h4000);

    // Asynchronous reset mid-run
    enc = 1; tick(); enc = 1; tick();
    chk("pre_rst_cnt", 32'(cnt_out), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_result", 32'(result), 32'h0);
    chk("async_cnt", 32'(cnt_out), 32'h0);
    chk("async_co", 32'(co), 32'h0);
    chk("async_gt", 32'(gt), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/series_datapath.md
Name: series_datapath

Overview:
- Arithmetic datapath driven by the series controller.
- Evaluates r = sum over k of (±) x^k/k! (e^-x style alternating series) in unsigned/signed Q2.14 fixed point.
- Consumes the controller strobes initr, initt, zc, ldx, s, ldt, enc, ldr and is_neg.
- Returns the status flags co and gt, and exposes the running result.

Parameters:
- W, 16, datapath word width (Q2.14; FRAC = W-2).
- CNT_W, 3, term-counter width; the series uses at most 2**CNT_W terms.
- EPS, 16'h0004, convergence threshold; gt asserts when the term is below this.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- x_in  in  W  operand x, unsigned Q2.14.
- initr  in  1  r_reg <= ONE (16'h4000).
- initt  in  1  t_reg <= ONE.
- zc  in  1  cnt <= 0.
- ldx  in  1  x_reg <= x_in.
- s  in  1  multiplier operand select: 0 = x_reg, 1 = coef[cnt].
- ldt  in  1  t_reg <= t_reg * operand.
- enc  in  1  cnt <= cnt + 1.
- ldr  in  1  r_reg <= r_reg ± t_reg.
- is_neg  in  1  1 = subtract t_reg during ldr; 0 = add.
- co  out  1  counter at terminal value.
- gt  out  1  term below threshold (series converged).
- result  out  W  r_reg, signed Q2.14.
- cnt_out  out  CNT_W  current term index, for debug.

Behaviour:
- Reset: x_reg, t_reg, r_reg and cnt all clear to 0. Consequently result = 0, cnt_out = 0, gt = 1 (0 < EPS) and co = 0.
- Registers:
  - All registers update on the rising edge of clk and have single-cycle latency.
  - co and gt are combinational from current register values.
- Multiply:
  - Form the 2W-bit product of t_reg and the selected operand.
  - The new t_reg is product[FRAC+W-1:FRAC], truncated.
  - If product[2W-1:FRAC+W] is nonzero, t_reg saturates to 16'hFFFF.
- Coefficient table: coef[k] = round(ONE/(k+1)), i.e. 4000, 2000, 1555, 1000, 0CCD, 0AAB, 0925, 0800 (hex, k = 0..7).
- Accumulate:
  - r_reg <= r_reg + t_reg, or r_reg - t_reg when is_neg = 1.
  - Two's complement; wraps silently modulo 2**W (no saturation).
  - t_reg is zero-extended into the signed add.
- gt = (t_reg < EPS), unsigned compare.
- co = (cnt == 2**CNT_W - 1). co is sampled by the controller before enc takes effect. enc when cnt is at maximum wraps cnt to 0.
- Simultaneous strobes:
  - initr beats ldr.
  - initt beats ldt.
  - zc beats enc.
  - ldx with ldt/s = 0 in the same cycle: the multiply uses the old x_reg.
- Strobe sequence per term (the controller guarantees this):
  - MULT1: s=0, ldt → t = t·x.
  - MULT2: s=1, ldt → t = t·coef[cnt].
  - ADD: enc, ldr.
- Reset mid-operation clears all state immediately, with no wait for the clock edge.
- With no strobes asserted, all registers hold.

Decomposition:
- Package series_pkg:
  - W, FRAC, ONE = 16'h4000 and EPS.
  - The coef_t typedef (logic [W-1:0]).
  - A constant coefficient array.
- Sub-module coef_rom:
  - CNT_W-bit address in, W-bit coefficient out.
  - Combinational case table.
- The counter, the multiplier with saturation and the add/sub unit stay inline.

Test Plan:
- Reset check: assert rst mid-run with registers nonzero → result=0, cnt_out=0, co=0, gt=1 before the next clk edge.
- Convergence on zero input: x_in=0; init (all four init strobes); one MULT1 → t=0, gt=1; result holds 16'h4000.
- Full series: x_in=16'h4000 (1.0); 8 term sequences with is_neg = 1,0,1,0,...
  - Terms are 4000, 2000, 0AAA…
  - After term 1, result = 16'h0000; after term 2, 16'h2000.
  - Final result within ±4 LSB of 16'h178B (e^-1).
  - co=1 exactly in the 8th ADD cycle.
- Counter wrap and priority: 8 enc pulses → cnt=0. zc+enc in the same cycle → cnt=0.
- Saturation: t_reg=16'h4000 and x_in=16'hFFFF (≈4.0); MULT1 → t_reg=16'hFFFF. MULT1 again → t_reg=16'hFFFF.
- Accumulator wrap: r=16'h4000, t=16'hC000, is_neg=0, ldr → result=16'h0000 (wrap). initr+ldr together → result=16'h4000.
